// File: rtl/bean_sched_pkg.sv
//------------------------------------------------------------------------------
// Module  : bean_sched_pkg
// Brief   : Shared maze constants, game-state encoding and tile index helper.
// Revision: 1.0
//------------------------------------------------------------------------------
`default_nettype none

package bean_sched_pkg;

  localparam int COLS       = 40;
  localparam int ROWS       = 30;
  localparam int MAP_SIZE   = COLS * ROWS;
  localparam int TOTAL      = 138;
  localparam int TILE_SHIFT = 4;
  localparam int SPRITE_OFF = 16;

  localparam int REQ_EAT = 0;
  localparam int REQ_RD  = 1;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_LOAD = 2'd1,
    ST_PLAY = 2'd2,
    ST_OVER = 2'd3
  } state_t;

  function automatic logic [10:0] tile_index(input logic [10:0] row, input logic [10:0] col);
    return 11'(row * 11'(COLS) + col);
  endfunction

endpackage

`default_nettype wire

// File: rtl/bean_rr_arb.sv
//------------------------------------------------------------------------------
// Module  : bean_rr_arb
// Brief   : Two-requester round-robin arbiter with busy mask, one-hot grant.
// Revision: 1.0
//------------------------------------------------------------------------------
`default_nettype none

module bean_rr_arb (
  input  logic       clk,
  input  logic       rst,
  input  logic [1:0] req,
  input  logic [1:0] busy,
  output logic [1:0] grant
);

  logic [1:0] w_elig;
  logic       r_prio;  // requester that wins the next tie

  assign w_elig = req & ~busy;

  always_comb begin
    grant = w_elig;
    if (w_elig == 2'b11) begin
      grant = r_prio ? 2'b10 : 2'b01;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_prio <= 1'b0;
    end else if (|grant) begin
      r_prio <= grant[0];
    end
  end

endmodule

`default_nettype wire

// File: rtl/bean_sched.sv
//------------------------------------------------------------------------------
// Module  : bean_sched
// Brief   : Bean bitmap owner, eat/render arbitration and game-flow FSM.
// Revision: 1.0
//------------------------------------------------------------------------------
`default_nettype none

module bean_sched
  import bean_sched_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  output logic [10:0] rom_addr,
  input  logic        rom_bit,
  input  logic        eat_req,
  input  logic [9:0]  pac_x,
  input  logic [8:0]  pac_y,
  output logic        eat_ack,
  output logic        eat_hit,
  input  logic        rd_req,
  input  logic [5:0]  rd_col,
  input  logic [4:0]  rd_row,
  output logic        rd_valid,
  output logic        rd_bean,
  output logic [8:0]  score,
  output logic [1:0]  state,
  output logic        isover
);

  logic [MAP_SIZE-1:0] r_map;
  state_t              r_state;
  logic [10:0]         r_cnt;
  logic                r_start_pend;

  logic [10:0] w_eat_col, w_eat_row, w_eat_idx, w_rd_idx, w_acc_idx, w_wr_idx;
  logic        w_eat_in, w_rd_in, w_acc_in, w_map_bit, w_hit;
  logic        w_wr_en, w_wr_val, w_active;
  logic [1:0]  w_grant, w_busy;

  assign w_eat_col = (11'(pac_x) + 11'(SPRITE_OFF)) >> TILE_SHIFT;
  assign w_eat_row = (11'(pac_y) + 11'(SPRITE_OFF)) >> TILE_SHIFT;
  assign w_eat_in  = (w_eat_col < 11'(COLS)) && (w_eat_row < 11'(ROWS));
  assign w_eat_idx = tile_index(w_eat_row, w_eat_col);

  assign w_rd_in  = (rd_col < 6'(COLS)) && (rd_row < 5'(ROWS));
  assign w_rd_idx = tile_index(11'(rd_row), 11'(rd_col));

  // A pending restart stops new grants so the in-flight op drains first.
  assign w_active = ((r_state == ST_PLAY) || (r_state == ST_OVER)) && !r_start_pend;
  assign w_busy   = {2{~w_active}};

  assign rom_addr = (r_cnt == 11'(MAP_SIZE)) ? 11'(MAP_SIZE - 1) : r_cnt;
  assign state    = r_state;

  bean_rr_arb u_arb (
    .clk   (clk),
    .rst   (rst),
    .req   ({rd_req, eat_req}),
    .busy  (w_busy),
    .grant (w_grant)
  );

  always_comb begin
    w_acc_in  = w_grant[REQ_EAT] ? w_eat_in : w_rd_in;
    w_acc_idx = 11'd0;
    if (w_acc_in) begin
      w_acc_idx = w_grant[REQ_EAT] ? w_eat_idx : w_rd_idx;
    end
    w_map_bit = w_acc_in & r_map[w_acc_idx];
    w_hit     = w_grant[REQ_EAT] && w_map_bit && (r_state == ST_PLAY) && (score != 9'(TOTAL));

    w_wr_en  = 1'b0;
    w_wr_idx = 11'd0;
    w_wr_val = 1'b0;
    if ((r_state == ST_LOAD) && (r_cnt != 11'd0)) begin
      w_wr_en  = 1'b1;
      w_wr_idx = 11'(r_cnt - 11'd1);
      w_wr_val = rom_bit;
    end else if (w_hit) begin
      w_wr_en  = 1'b1;
      w_wr_idx = w_eat_idx;
      w_wr_val = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state      <= ST_IDLE;
      r_map        <= '0;
      r_cnt        <= '0;
      r_start_pend <= 1'b0;
      score        <= '0;
      eat_ack      <= 1'b0;
      eat_hit      <= 1'b0;
      rd_valid     <= 1'b0;
      rd_bean      <= 1'b0;
      isover       <= 1'b0;
    end else begin
      eat_ack  <= w_grant[REQ_EAT];
      rd_valid <= w_grant[REQ_RD];
      if (w_grant[REQ_EAT]) eat_hit <= w_hit;
      if (w_grant[REQ_RD])  rd_bean <= w_map_bit;
      if (w_hit)            score   <= score + 9'd1;
      if (w_wr_en)          r_map[w_wr_idx] <= w_wr_val;

      case (r_state)
        ST_IDLE: begin
          if (start) begin
            r_state <= ST_LOAD;
            r_cnt   <= '0;
            score   <= '0;
          end
        end
        ST_LOAD: begin
          // ROM data lags the address by one cycle, so the last write lands at count MAP_SIZE.
          if (start) begin
            r_cnt <= '0;
          end else if (r_cnt == 11'(MAP_SIZE)) begin
            r_state <= ST_PLAY;
            r_cnt   <= '0;
          end else begin
            r_cnt <= r_cnt + 11'd1;
          end
        end
        default: begin
          if (start) r_start_pend <= 1'b1;
          if (r_start_pend) begin
            r_state      <= ST_LOAD;
            r_cnt        <= '0;
            score        <= '0;
            isover       <= 1'b0;
            r_start_pend <= 1'b0;
          end else if ((r_state == ST_PLAY) && (score == 9'(TOTAL))) begin
            r_state <= ST_OVER;
            isover  <= 1'b1;
          end
        end
      endcase
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_bean_sched.sv
//------------------------------------------------------------------------------
// Module  : tb_bean_sched
// Brief   : Directed, table-driven self-checking bench for bean_sched.
// Revision: 1.0
//------------------------------------------------------------------------------
`timescale 1ns/1ps
`default_nettype none

module tb_bean_sched;

  logic        clk = 1'b0;
  logic        rst, start, rom_bit, eat_req, rd_req;
  logic [10:0] rom_addr;
  logic [9:0]  pac_x;
  logic [8:0]  pac_y;
  logic [5:0]  rd_col;
  logic [4:0]  rd_row;
  logic        eat_ack, eat_hit, rd_valid, rd_bean, isover;
  logic [8:0]  score;
  logic [1:0]  state;

  int checks = 0;
  int errors = 0;
  bit exp_map [1200];
  int exp_score;

  typedef struct {
    bit is_eat;
    int a;
    int b;
    int exp_val;
    int exp_score;
  } vec_t;
  vec_t vecs [16];

  always #5 clk = ~clk;

  bean_sched dut (
    .clk(clk), .rst(rst), .start(start), .rom_addr(rom_addr), .rom_bit(rom_bit),
    .eat_req(eat_req), .pac_x(pac_x), .pac_y(pac_y), .eat_ack(eat_ack), .eat_hit(eat_hit),
    .rd_req(rd_req), .rd_col(rd_col), .rd_row(rd_row), .rd_valid(rd_valid), .rd_bean(rd_bean),
    .score(score), .state(state), .isover(isover)
  );

  // Standard map: two horizontal walls, two vertical walls and a middle bar = 138 beans.
  function automatic bit rom_model(input int idx);
    int r, c;
    r = idx / 40;
    c = idx % 40;
    if (idx >= 1200) return 1'b0;
    if ((r == 2 || r == 27) && c >= 2 && c <= 37) return 1'b1;
    if ((c == 2 || c == 37) && r >= 3 && r <= 26) return 1'b1;
    if (r == 14 && c >= 11 && c <= 28) return 1'b1;
    return 1'b0;
  endfunction

  always @(posedge clk) rom_bit <= rom_model(int'(rom_addr));

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_op(input bit is_eat, input int a, input int b, output int lat, output bit val);
    lat = 0;
    if (is_eat) begin
      pac_x = 10'(a); pac_y = 9'(b); eat_req = 1'b1;
    end else begin
      rd_col = 6'(a); rd_row = 5'(b); rd_req = 1'b1;
    end
    for (int i = 0; i < 8; i++) begin
      tick();
      lat++;
      if (is_eat ? eat_ack : rd_valid) break;
    end
    val = is_eat ? eat_hit : rd_bean;
    eat_req = 1'b0;
    rd_req  = 1'b0;
  endtask

  task automatic wait_state(input int st, input int bound);
    for (int i = 0; i < bound; i++) begin
      if (int'(state) == st) break;
      tick();
    end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int lat, cnt, idx;
    bit val;

    vecs[0]  = '{0,   2,   2, 1, 0};
    vecs[1]  = '{0,   0,   0, 0, 0};
    vecs[2]  = '{1,  16,  16, 1, 1};
    vecs[3]  = '{1,  16,  16, 0, 1};
    vecs[4]  = '{0,   2,   2, 0, 1};
    vecs[5]  = '{1, 640,  16, 0, 1};
    vecs[6]  = '{1, 1023, 16, 0, 1};
    vecs[7]  = '{0,  63,  31, 0, 1};
    vecs[8]  = '{0,  37,   2, 1, 1};
    vecs[9]  = '{1, 576,  16, 1, 2};
    vecs[10] = '{0,  37,   2, 0, 2};
    vecs[11] = '{1,  16, 464, 0, 2};
    vecs[12] = '{0,  11,  14, 1, 2};
    vecs[13] = '{0,  10,  14, 0, 2};
    vecs[14] = '{1,  16, 416, 1, 3};
    vecs[15] = '{0,  39,  29, 0, 3};

    for (int i = 0; i < 1200; i++) exp_map[i] = rom_model(i);

    rst = 1'b1; start = 1'b0; eat_req = 1'b0; rd_req = 1'b0;
    pac_x = '0; pac_y = '0; rd_col = '0; rd_row = '0;
    tick(); tick();
    check("reset state", int'(state), 0);
    check("reset score", int'(score), 0);
    check("reset rom_addr", int'(rom_addr), 0);
    check("reset acks", int'({eat_ack, eat_hit, rd_valid, rd_bean}), 0);
    check("reset isover", int'(isover), 0);
    rst = 1'b0;
    tick();

    // Initial load
    start = 1'b1;
    tick();
    start = 1'b0;
    check("load first addr", int'(rom_addr), 0);
    cnt = 0;
    for (int i = 0; i < 1400; i++) begin
      if (int'(state) != 1) break;
      cnt++;
      tick();
    end
    check("load length", cnt, 1201);
    check("play after load", int'(state), 2);
    check("score after load", int'(score), 0);

    foreach (vecs[i]) begin
      do_op(vecs[i].is_eat, vecs[i].a, vecs[i].b, lat, val);
      check($sformatf("vec%0d latency", i), lat, 1);
      check($sformatf("vec%0d value", i), int'(val), vecs[i].exp_val);
      check($sformatf("vec%0d score", i), int'(score), vecs[i].exp_score);
      if (vecs[i].is_eat && vecs[i].exp_val == 1) begin
        idx = ((vecs[i].b + 16) >> 4) * 40 + ((vecs[i].a + 16) >> 4);
        exp_map[idx] = 1'b0;
      end
    end
    exp_score = 3;

    // Contention: both requesters held, grants must alternate starting with eat
    pac_x = 10'd640; pac_y = 9'd16; eat_req = 1'b1;
    rd_col = 6'd2; rd_row = 5'd26; rd_req = 1'b1;
    for (int k = 1; k <= 6; k++) begin
      tick();
      check($sformatf("rr%0d eat_ack", k), int'(eat_ack), (k % 2 == 1) ? 1 : 0);
      check($sformatf("rr%0d rd_valid", k), int'(rd_valid), (k % 2 == 0) ? 1 : 0);
    end
    eat_req = 1'b0; rd_req = 1'b0;
    check("rr eat_hit", int'(eat_hit), 0);
    check("rr rd_bean", int'(rd_bean), 1);
    check("rr score", int'(score), exp_score);
    tick();
    check("rr idle acks", int'({eat_ack, rd_valid}), 0);

    // Eat every remaining bean
    for (int i = 0; i < 1200; i++) begin
      if (exp_map[i]) begin
        do_op(1'b1, (i % 40 - 1) * 16, (i / 40 - 1) * 16, lat, val);
        exp_map[i] = 1'b0;
        exp_score++;
        check($sformatf("eatall %0d hit", i), int'(val), 1);
        check($sformatf("eatall %0d score", i), int'(score), exp_score);
      end
    end
    check("final score", int'(score), 138);
    check("state at final ack", int'(state), 2);
    tick();
    check("over state", int'(state), 3);
    check("over isover", int'(isover), 1);

    do_op(1'b1, 16, 16, lat, val);
    check("over eat latency", lat, 1);
    check("over eat hit", int'(val), 0);
    check("over score held", int'(score), 138);
    do_op(1'b0, 2, 26, lat, val);
    check("over read latency", lat, 1);
    check("over read bean", int'(val), 0);

    // Restart from OVER
    start = 1'b1;
    tick();
    start = 1'b0;
    check("restart pending state", int'(state), 3);
    tick();
    check("restart load state", int'(state), 1);
    check("restart score", int'(score), 0);
    check("restart isover", int'(isover), 0);
    wait_state(2, 1300);
    check("restart play", int'(state), 2);
    do_op(1'b0, 2, 2, lat, val);
    check("restored (2,2)", int'(val), 1);
    do_op(1'b0, 11, 14, lat, val);
    check("restored (11,14)", int'(val), 1);

    // Asynchronous reset in the middle of a load
    start = 1'b1;
    tick();
    start = 1'b0;
    wait_state(1, 10);
    for (int i = 0; i < 1300; i++) begin
      if (int'(rom_addr) == 500) break;
      tick();
    end
    check("mid-load addr", int'(rom_addr), 500);
    #2;
    rst = 1'b1;
    #1;
    check("async rst state", int'(state), 0);
    check("async rst rom_addr", int'(rom_addr), 0);
    check("async rst score", int'(score), 0);
    check("async rst acks", int'({eat_ack, eat_hit, rd_valid, rd_bean, isover}), 0);
    tick(); tick();
    rst = 1'b0;
    tick();
    check("idle after rst", int'(state), 0);
    start = 1'b1;
    tick();
    start = 1'b0;
    check("reload state", int'(state), 1);
    check("reload addr0", int'(rom_addr), 0);
    tick();
    check("reload addr1", int'(rom_addr), 1);
    wait_state(2, 1300);
    check("reload play", int'(state), 2);
    do_op(1'b0, 2, 2, lat, val);
    check("reload (2,2)", int'(val), 1);
    do_op(1'b0, 0, 0, lat, val);
    check("reload (0,0)", int'(val), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire
